// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic ops and a WIDTH-cycle shift-add multiply.
// Results and flags hold between operations; start/busy/done handshake toward the control FSM.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                           OP_OR  = 3'b011, OP_XOR = 3'b100, OP_NOT = 3'b101,
                           OP_MUL = 3'b110, OP_ACC = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0]   r_q, r_d, r_hi_q, r_hi_d;
    logic               zero_q, zero_d, carry_q, carry_d, sign_q, sign_d, ovf_q, ovf_d;
    logic               done_q, done_d, wr;
    logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, addend, prod_nxt;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opx, opy;
    logic               cin;
    logic [WIDTH:0]     sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && op == OP_MUL) state_d = MUL;
            MUL:  if (cnt_q == LAST)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == MUL);
    end

    // Adder is shared by ADD, SUB (a + ~b + 1) and ACC (r + a + c_in).
    always_comb begin
        opx = a;
        opy = b;
        cin = c_in;
        case (op)
            OP_SUB: begin opy = ~b; cin = 1'b1; end
            OP_ACC: begin opx = r_q; opy = a; end
            default: ;
        endcase
        sum = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        addend   = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
        prod_nxt = prod_q + addend;
    end

    always_comb begin
        r_d      = r_q;
        r_hi_d   = r_hi_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        wr       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (op == OP_MUL) begin
                    mcand_d  = a;
                    mplier_d = b;
                    prod_d   = '0;
                    cnt_d    = '0;
                end else begin
                    wr      = 1'b1;
                    r_hi_d  = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    case (op)
                        OP_ADD, OP_SUB, OP_ACC: begin
                            r_d     = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                            ovf_d   = (opx[WIDTH-1] == opy[WIDTH-1]) &&
                                      (sum[WIDTH-1] != opx[WIDTH-1]);
                        end
                        OP_AND:  r_d = a & b;
                        OP_OR:   r_d = a | b;
                        OP_XOR:  r_d = a ^ b;
                        default: r_d = ~a;
                    endcase
                end
            end
            MUL: begin
                prod_d   = prod_nxt;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    wr      = 1'b1;
                    r_d     = prod_nxt[WIDTH-1:0];
                    r_hi_d  = prod_nxt[2*WIDTH-1:WIDTH];
                    carry_d = |prod_nxt[2*WIDTH-1:WIDTH];
                    ovf_d   = |prod_nxt[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
        zero_d = wr ? (r_d == '0) : zero_q;
        sign_d = wr ? r_d[WIDTH-1] : sign_q;
        done_d = wr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q      <= '0;
            r_hi_q   <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            r_q      <= r_d;
            r_hi_q   <= r_hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done  = done_q;
    assign r     = r_q;
    assign r_hi  = r_hi_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign sign  = sign_q;
    assign ovf   = ovf_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the 4-bit combinational ALU.
- WIDTH-bit operands; single-cycle add/sub/logic ops and an accumulate op; multi-cycle shift-add multiply with double-width product.
- Result and flags (zero, carry, sign, overflow) are registered and held between operations.
- Sits between the register file / operand muxes and the control FSM of the datapath, using a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  operation code, captured with start
a  input  WIDTH  operand A, captured with start
b  input  WIDTH  operand B, captured with start
c_in  input  1  carry-in for ADD and ACC, captured with start
busy  output  1  high while a MUL is in progress
done  output  1  one-cycle pulse: r/flags were updated at this edge
r  output  WIDTH  result (low half of product for MUL)
r_hi  output  WIDTH  high half of product for MUL; 0 for all other ops
zero  output  1  registered: r == 0
carry  output  1  registered carry / no-borrow / product-high-nonzero
sign  output  1  registered r[WIDTH-1]
ovf  output  1  registered two's-complement overflow

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, r, r_hi, zero, carry, sign and ovf = 0; internal counter and shift registers = 0. Asserting reset mid-MUL aborts the operation and discards the partial product.
- States: IDLE and MUL.
- IDLE with start=1 at edge k, op != 110:
  - r, r_hi and flags are written at edge k.
  - done=1 for the cycle after edge k.
  - State stays IDLE, so a new start is accepted at edge k+1 (back-to-back issue).
- IDLE with start=1 at edge k, op = 110 (MUL):
  - Edge k: capture a, b; r_hi/r accumulator = 0; counter = 0; busy=1; state=MUL.
  - Edges k+1..k+WIDTH: one shift-add iteration each (LSB-first on b).
  - Edge k+WIDTH: write {r_hi, r} = a*b (unsigned); flags update; done=1; busy=0; state=IDLE.
  - Latency: WIDTH cycles from the start edge to done.
- start while busy=1 is ignored, with no effect on the operation in flight.
- done is low in every cycle not listed above.
- r and flags hold their values until the next completing operation.
- Op encoding (all sums WIDTH+1 bits wide, carry = bit WIDTH):
  - 000 ADD: a + b + c_in; ovf = signed overflow.
  - 001 SUB: a + ~b + 1; c_in ignored; carry=1 means no borrow (a >= b unsigned); ovf = signed overflow.
  - 010 AND, 011 OR, 100 XOR: carry=0, ovf=0.
  - 101 NOT: ~a; carry=0, ovf=0.
  - 110 MUL: carry = ovf = (r_hi != 0).
  - 111 ACC: r + a + c_in, using the current registered r; flags as for ADD.
- r_hi is forced to 0 by every non-MUL op.
- zero and sign are always computed from the new r (r_hi excluded).

Test Plan:
- WIDTH=8, reset then ADD a=F0 b=20 c_in=0 -> next cycle r=10, carry=1, zero=0, sign=0, ovf=0, done=1 for exactly 1 cycle.
- ADD a=7F b=01 -> r=80, sign=1, ovf=1, carry=0; then SUB a=05 b=05 -> r=00, zero=1, carry=1; SUB a=03 b=05 -> r=FE, carry=0, sign=1.
- MUL a=FF b=FF -> busy=1 for 8 cycles; done at start+8: r=01, r_hi=FE, carry=1, ovf=1. MUL a=0F b=11 -> r=FF, r_hi=00, carry=0.
- During MUL, pulse start with op=000 a=01 b=01 -> ignored; MUL result unchanged and exactly one done pulse.
- Reset asserted 3 cycles into a MUL -> all outputs 0 immediately, busy=0. A fresh ADD 01+01 afterwards -> r=02.
- Back-to-back single-cycle issue: ADD 10+20 then ACC a=05 c_in=1 on consecutive cycles -> r=30, then r=36; done high on both cycles. Then AND F0/3C -> r=30, carry=0. XOR FF/FF -> zero=1.
